// File: rtl/matmul_host_ctrl_if.sv
// Host-side bundle between the job source/sink, the accelerator SRAMs and the start handshake.
// master = controller side, slave = environment side.
interface matmul_host_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [15:0]       cfg_a_rows;
  logic [15:0]       cfg_a_cols;
  logic [15:0]       cfg_b_cols;
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              dut_valid;
  logic              dut_ready;
  logic              sram_input_we;
  logic [ADDR_W-1:0] sram_input_waddr;
  logic [DATA_W-1:0] sram_input_wdata;
  logic              sram_weight_we;
  logic [ADDR_W-1:0] sram_weight_waddr;
  logic [DATA_W-1:0] sram_weight_wdata;
  logic [ADDR_W-1:0] sram_result_raddr;
  logic [DATA_W-1:0] sram_result_rdata;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_last;
  logic              job_done;
  logic              job_err;

  modport master (
    input  cfg_valid, cfg_a_rows, cfg_a_cols, cfg_b_cols,
    input  ld_valid, ld_data, dut_ready, sram_result_rdata, res_ready,
    output cfg_ready, ld_ready, dut_valid,
    output sram_input_we, sram_input_waddr, sram_input_wdata,
    output sram_weight_we, sram_weight_waddr, sram_weight_wdata,
    output sram_result_raddr, res_valid, res_data, res_last, job_done, job_err
  );

  modport slave (
    output cfg_valid, cfg_a_rows, cfg_a_cols, cfg_b_cols,
    output ld_valid, ld_data, dut_ready, sram_result_rdata, res_ready,
    input  cfg_ready, ld_ready, dut_valid,
    input  sram_input_we, sram_input_waddr, sram_input_wdata,
    input  sram_weight_we, sram_weight_waddr, sram_weight_wdata,
    input  sram_result_raddr, res_valid, res_data, res_last, job_done, job_err
  );
endinterface

// File: rtl/matmul_host_ctrl.sv
// Host controller: config -> header/operand SRAM writes -> accelerator start/wait -> result stream.
// Operand writes happen in the accepting cycle; results stream at 1 word/cycle through a 2-entry buffer, stalled by res_ready.
module matmul_host_ctrl #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  matmul_host_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, HDR, LOAD_A, LOAD_B, START, WAIT_DONE, READ, DONE} state_t;

  localparam logic [32:0] ADDR_SPAN = 33'd1 << ADDR_W;
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [15:0]       m_q, k_q, n_q;
  logic [31:0]       mk_q, kn_q, mn_q;
  logic [31:0]       beat_cnt, tmo_cnt, rd_cnt;
  logic              cfg_ready_q, ld_ready_q, dut_valid_q, job_done_q, job_err_q;
  logic              rd_inflight, rd_inflight_last;
  logic [DATA_W-1:0] buf_dat [2];
  logic              buf_lst [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        buf_cnt;

  logic [31:0] cfg_mk, cfg_kn, cfg_mn;
  logic        cfg_bad;
  logic        ld_fire, pop, rd_issue;
  logic [1:0]  occ;

  assign cfg_mk = 32'(bus.cfg_a_rows) * 32'(bus.cfg_a_cols);
  assign cfg_kn = 32'(bus.cfg_a_cols) * 32'(bus.cfg_b_cols);
  assign cfg_mn = 32'(bus.cfg_a_rows) * 32'(bus.cfg_b_cols);

  // Zero dimensions or any region that would not fit the SRAM address space (header takes addr 0).
  assign cfg_bad = (bus.cfg_a_rows == 16'd0) || (bus.cfg_a_cols == 16'd0) || (bus.cfg_b_cols == 16'd0) ||
                   (({1'b0, cfg_mk} + 33'd1) > ADDR_SPAN) ||
                   (({1'b0, cfg_kn} + 33'd1) > ADDR_SPAN) ||
                   ({1'b0, cfg_mn} > ADDR_SPAN);

  assign ld_fire = bus.ld_valid & ld_ready_q;
  assign pop     = bus.res_valid & bus.res_ready;
  assign occ     = buf_cnt + {1'b0, rd_inflight};
  // A pop in the same cycle frees a slot, which is what sustains one word per cycle.
  assign rd_issue = (state == READ) && (rd_cnt < mn_q) && ((occ < 2'd2) || pop);

  assign bus.cfg_ready         = cfg_ready_q;
  assign bus.ld_ready          = ld_ready_q;
  assign bus.dut_valid         = dut_valid_q;
  assign bus.job_done          = job_done_q;
  assign bus.job_err           = job_err_q;
  assign bus.sram_result_raddr = rd_cnt[ADDR_W-1:0];
  assign bus.res_valid         = (buf_cnt != 2'd0);
  assign bus.res_data          = buf_dat[rd_ptr];
  assign bus.res_last          = bus.res_valid & buf_lst[rd_ptr];

  always_comb begin
    bus.sram_input_we     = 1'b0;
    bus.sram_input_waddr  = '0;
    bus.sram_input_wdata  = '0;
    bus.sram_weight_we    = 1'b0;
    bus.sram_weight_waddr = '0;
    bus.sram_weight_wdata = '0;
    case (state)
      HDR: begin
        bus.sram_input_we     = 1'b1;
        bus.sram_input_wdata  = DATA_W'({m_q, k_q});
        bus.sram_weight_we    = 1'b1;
        bus.sram_weight_wdata = DATA_W'({k_q, n_q});
      end
      LOAD_A: begin
        bus.sram_input_we    = ld_fire;
        bus.sram_input_waddr = ADDR_W'(beat_cnt + 32'd1);
        bus.sram_input_wdata = bus.ld_data;
      end
      LOAD_B: begin
        bus.sram_weight_we    = ld_fire;
        bus.sram_weight_waddr = ADDR_W'(beat_cnt + 32'd1);
        bus.sram_weight_wdata = bus.ld_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      cfg_ready_q      <= 1'b1;
      ld_ready_q       <= 1'b0;
      dut_valid_q      <= 1'b0;
      job_done_q       <= 1'b0;
      job_err_q        <= 1'b0;
      m_q              <= '0;
      k_q              <= '0;
      n_q              <= '0;
      mk_q             <= '0;
      kn_q             <= '0;
      mn_q             <= '0;
      beat_cnt         <= '0;
      tmo_cnt          <= '0;
      rd_cnt           <= '0;
      rd_inflight      <= 1'b0;
      rd_inflight_last <= 1'b0;
      wr_ptr           <= 1'b0;
      rd_ptr           <= 1'b0;
      buf_cnt          <= '0;
    end else begin
      job_done_q       <= 1'b0;
      rd_inflight      <= rd_issue;
      rd_inflight_last <= rd_issue && (rd_cnt == mn_q - 32'd1);
      if (rd_issue) rd_cnt <= rd_cnt + 32'd1;
      if (rd_inflight) begin
        buf_dat[wr_ptr] <= bus.sram_result_rdata;
        buf_lst[wr_ptr] <= rd_inflight_last;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      buf_cnt <= buf_cnt + {1'b0, rd_inflight} - {1'b0, pop};

      case (state)
        IDLE: if (bus.cfg_valid) begin
          m_q         <= bus.cfg_a_rows;
          k_q         <= bus.cfg_a_cols;
          n_q         <= bus.cfg_b_cols;
          mk_q        <= cfg_mk;
          kn_q        <= cfg_kn;
          mn_q        <= cfg_mn;
          beat_cnt    <= '0;
          rd_cnt      <= '0;
          cfg_ready_q <= 1'b0;
          if (cfg_bad) begin
            job_err_q  <= 1'b1;
            job_done_q <= 1'b1;
            state      <= DONE;
          end else begin
            job_err_q <= 1'b0;
            state     <= HDR;
          end
        end
        HDR: begin
          ld_ready_q <= 1'b1;
          state      <= LOAD_A;
        end
        LOAD_A: if (ld_fire) begin
          if (beat_cnt == mk_q - 32'd1) begin
            beat_cnt <= '0;
            state    <= LOAD_B;
          end else begin
            beat_cnt <= beat_cnt + 32'd1;
          end
        end
        LOAD_B: if (ld_fire) begin
          if (beat_cnt == kn_q - 32'd1) begin
            beat_cnt    <= '0;
            ld_ready_q  <= 1'b0;
            dut_valid_q <= 1'b1;
            tmo_cnt     <= '0;
            state       <= START;
          end else begin
            beat_cnt <= beat_cnt + 32'd1;
          end
        end
        START, WAIT_DONE: begin
          if (tmo_cnt == TMO_LAST) begin
            dut_valid_q <= 1'b0;
            job_err_q   <= 1'b1;
            job_done_q  <= 1'b1;
            state       <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
            if (state == START && !bus.dut_ready) begin
              dut_valid_q <= 1'b0;
              state       <= WAIT_DONE;
            end else if (state == WAIT_DONE && bus.dut_ready) begin
              state <= READ;
            end
          end
        end
        READ: if (pop && bus.res_last) begin
          job_done_q <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          cfg_ready_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
